// File: rtl/mii_tx_frame_encoder_pkg.sv
// Shared MII transmit constants and the encoder state type, also used by the stream checker.
package mii_pkg;

  localparam int MII_DATA_W = 64;
  localparam int MII_CTRL_W = 8;

  localparam logic [7:0] IDLE_CODE  = 8'h07;
  localparam logic [7:0] START_CODE = 8'hFB;
  localparam logic [7:0] TERM_CODE  = 8'hFD;
  localparam logic [7:0] ERROR_CODE = 8'hFE;
  localparam logic [7:0] PREAMBLE   = 8'h55;
  localparam logic [7:0] SFD        = 8'hD5;

  typedef enum logic [2:0] {IDLE, DATA, TERM, DRAIN, IFG} tx_state_t;

  // A keep mask is usable only if it is non-empty and its ones run contiguously up from lane 0.
  function automatic logic keep_contig(input logic [MII_CTRL_W-1:0] keep);
    return (keep != {MII_CTRL_W{1'b0}}) &&
           ((keep & (keep + MII_CTRL_W'(1))) == {MII_CTRL_W{1'b0}});
  endfunction

endpackage

// File: rtl/mii_tx_frame_encoder_if.sv
// Payload stream between the MAC payload source (master) and the MII column encoder (slave).
interface mii_tx_frame_encoder_if #(
  parameter int DATA_WIDTH = mii_pkg::MII_DATA_W,
  parameter int CTRL_WIDTH = mii_pkg::MII_CTRL_W
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic                  last;
  logic [CTRL_WIDTH-1:0] keep;

  modport master (output valid, data, last, keep, input ready);
  modport slave  (input valid, data, last, keep, output ready);
endinterface

// File: rtl/mii_tx_frame_encoder_term_lane_encoder.sv
// Builds the terminate column for a partial last word: kept lanes carry data, the first
// unkept lane carries the terminate code and the rest are idle.
module mii_term_lane_encoder
  import mii_pkg::*;
#(
  parameter int CTRL_WIDTH = MII_CTRL_W,
  parameter int DATA_WIDTH = 8 * CTRL_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [CTRL_WIDTH-1:0] i_keep,
  output logic [DATA_WIDTH-1:0] o_term_data,
  output logic [CTRL_WIDTH-1:0] o_term_ctrl,
  output logic                  o_keep_ok
);

  logic [CTRL_WIDTH-1:0] prev_keep_s;

  assign prev_keep_s = {i_keep[CTRL_WIDTH-2:0], 1'b1};

  // Lane-by-lane selection of data, terminate or idle byte
  always_comb begin
    o_term_data = {DATA_WIDTH{1'b0}};
    for (int n = 0; n < CTRL_WIDTH; n++) begin
      if (i_keep[n]) begin
        o_term_data[8*n +: 8] = i_data[8*n +: 8];
      end else if (prev_keep_s[n]) begin
        o_term_data[8*n +: 8] = TERM_CODE;
      end else begin
        o_term_data[8*n +: 8] = IDLE_CODE;
      end
    end
  end

  assign o_term_ctrl = ~i_keep;
  assign o_keep_ok   = keep_contig(i_keep);

endmodule

// File: rtl/mii_tx_frame_encoder.sv
// MII transmit column encoder: payload stream -> idle/start/data/terminate/error columns.
// Define MII_TX_STATS_EN to enable the clean/aborted frame counters.
module mii_tx_frame_encoder
  import mii_pkg::*;
#(
  parameter int DATA_WIDTH = MII_DATA_W,
  parameter int CTRL_WIDTH = MII_CTRL_W,
  parameter int MIN_IFG    = 2,
  parameter int MAX_WORDS  = 192
) (
  input  logic                   clk,
  input  logic                   i_rst,
  mii_tx_frame_encoder_if.slave  s_in,
  output logic [DATA_WIDTH-1:0]  o_tx_data,
  output logic [CTRL_WIDTH-1:0]  o_tx_ctrl,
  output logic [15:0]            o_frame_cnt,
  output logic [15:0]            o_err_cnt
);

  localparam int WCNT_W = ($clog2(MAX_WORDS + 1) > 8) ? $clog2(MAX_WORDS + 1) : 8;
  localparam int IFG_W  = ($clog2(MIN_IFG + 1) > 1) ? $clog2(MIN_IFG + 1) : 1;

  localparam logic [DATA_WIDTH-1:0] IDLE_COL  = {CTRL_WIDTH{IDLE_CODE}};
  localparam logic [DATA_WIDTH-1:0] ERR_COL   = {CTRL_WIDTH{ERROR_CODE}};
  localparam logic [DATA_WIDTH-1:0] START_COL = {SFD, {(CTRL_WIDTH-2){PREAMBLE}}, START_CODE};
  localparam logic [DATA_WIDTH-1:0] TERM_COL  = {{(CTRL_WIDTH-1){IDLE_CODE}}, TERM_CODE};
  localparam logic [CTRL_WIDTH-1:0] CTRL_ALL   = {CTRL_WIDTH{1'b1}};
  localparam logic [CTRL_WIDTH-1:0] CTRL_NONE  = {CTRL_WIDTH{1'b0}};
  localparam logic [CTRL_WIDTH-1:0] START_CTRL = {{(CTRL_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WCNT_W-1:0]     WCNT_MAX   = WCNT_W'(MAX_WORDS);
  localparam logic [IFG_W-1:0]      IFG_LAST   = IFG_W'(MIN_IFG - 1);

  tx_state_t             state_r, state_s;
  logic [DATA_WIDTH-1:0] tx_data_r, tx_data_s;
  logic [CTRL_WIDTH-1:0] tx_ctrl_r, tx_ctrl_s;
  logic [WCNT_W-1:0]     word_cnt_r, word_cnt_s;
  logic [IFG_W-1:0]      ifg_cnt_r, ifg_cnt_s;
  logic [DATA_WIDTH-1:0] term_data_s;
  logic [CTRL_WIDTH-1:0] term_ctrl_s;
  logic                  keep_ok_s;

  mii_term_lane_encoder #(.CTRL_WIDTH(CTRL_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_term (
    .i_data      (s_in.data),
    .i_keep      (s_in.keep),
    .o_term_data (term_data_s),
    .o_term_ctrl (term_ctrl_s),
    .o_keep_ok   (keep_ok_s)
  );

  assign s_in.ready = (state_r == DATA) || (state_r == DRAIN);
  assign o_tx_data  = tx_data_r;
  assign o_tx_ctrl  = tx_ctrl_r;

  // Next state, next column and counter updates
  always_comb begin
    state_s    = state_r;
    tx_data_s  = IDLE_COL;
    tx_ctrl_s  = CTRL_ALL;
    word_cnt_s = word_cnt_r;
    ifg_cnt_s  = {IFG_W{1'b0}};
    case (state_r)
      IDLE: begin
        if (s_in.valid) begin
          tx_data_s  = START_COL;
          tx_ctrl_s  = START_CTRL;
          word_cnt_s = {WCNT_W{1'b0}};
          state_s    = DATA;
        end else begin
          state_s = IDLE;
        end
      end
      DATA: begin
        if (!s_in.valid) begin
          tx_data_s = ERR_COL;
          state_s   = DRAIN;
        end else if (!s_in.last) begin
          if (word_cnt_r == WCNT_MAX) begin
            tx_data_s = ERR_COL;
            state_s   = DRAIN;
          end else begin
            tx_data_s  = s_in.data;
            tx_ctrl_s  = CTRL_NONE;
            word_cnt_s = word_cnt_r + WCNT_W'(1);
          end
        end else if (s_in.keep == CTRL_ALL) begin
          tx_data_s = s_in.data;
          tx_ctrl_s = CTRL_NONE;
          state_s   = TERM;
        end else if (keep_ok_s) begin
          tx_data_s = term_data_s;
          tx_ctrl_s = term_ctrl_s;
          state_s   = IFG;
        end else begin
          tx_data_s = ERR_COL;
          state_s   = IFG;
        end
      end
      TERM: begin
        tx_data_s = TERM_COL;
        state_s   = IFG;
      end
      DRAIN: begin
        if (s_in.valid && s_in.last) begin
          state_s = IFG;
        end else begin
          state_s = DRAIN;
        end
      end
      IFG: begin
        if (ifg_cnt_r == IFG_LAST) begin
          state_s = IDLE;
        end else begin
          ifg_cnt_s = ifg_cnt_r + IFG_W'(1);
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, output column and frame-position registers
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_r    <= IDLE;
      tx_data_r  <= IDLE_COL;
      tx_ctrl_r  <= CTRL_ALL;
      word_cnt_r <= {WCNT_W{1'b0}};
      ifg_cnt_r  <= {IFG_W{1'b0}};
    end else begin
      state_r    <= state_s;
      tx_data_r  <= tx_data_s;
      tx_ctrl_r  <= tx_ctrl_s;
      word_cnt_r <= word_cnt_s;
      ifg_cnt_r  <= ifg_cnt_s;
    end
  end

`ifdef MII_TX_STATS_EN
  logic        clean_s, abort_s;
  logic [15:0] frame_cnt_r, err_cnt_r;

  // In DATA an all-ones ctrl can only be an error column; a mixed ctrl is a partial terminate
  assign abort_s = (state_r == DATA) && (tx_ctrl_s == CTRL_ALL);
  assign clean_s = (state_r == TERM) ||
                   ((state_r == DATA) && (tx_ctrl_s != CTRL_ALL) && (tx_ctrl_s != CTRL_NONE));

  // Clean and aborted frame counters, wrapping at 16 bits
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      frame_cnt_r <= 16'h0000;
      err_cnt_r   <= 16'h0000;
    end else begin
      if (clean_s) frame_cnt_r <= frame_cnt_r + 16'h0001;
      if (abort_s) err_cnt_r   <= err_cnt_r + 16'h0001;
    end
  end

  assign o_frame_cnt = frame_cnt_r;
  assign o_err_cnt   = err_cnt_r;
`else
  assign o_frame_cnt = 16'h0000;
  assign o_err_cnt   = 16'h0000;
`endif

endmodule

// File: tb/tb_mii_tx_frame_encoder.sv
// Randomized frame stream checked column-by-column against a frame-level reference model.
module tb_mii_tx_frame_encoder;
  import mii_pkg::*;

  localparam int MAXW  = 4;
  localparam int IFG_N = 2;
  localparam logic [63:0] IDLE64  = 64'h0707070707070707;
  localparam logic [63:0] ERR64   = 64'hFEFEFEFEFEFEFEFE;
  localparam logic [63:0] START64 = 64'hD5555555555555FB;
  localparam logic [63:0] TERM64  = 64'h07070707070707FD;

  typedef struct packed {
    logic        eof;
    logic [7:0]  ctrl;
    logic [63:0] data;
  } col_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] tx_data;
  logic [7:0]  tx_ctrl;
  logic [15:0] frame_cnt, err_cnt;

  mii_tx_frame_encoder_if bus ();

  mii_tx_frame_encoder #(.MIN_IFG(IFG_N), .MAX_WORDS(MAXW)) dut (
    .clk         (clk),
    .i_rst       (rst),
    .s_in        (bus),
    .o_tx_data   (tx_data),
    .o_tx_ctrl   (tx_ctrl),
    .o_frame_cnt (frame_cnt),
    .o_err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  col_t        exp_q[$];
  bit          cmp_en = 1'b0;
  bit          in_frame = 1'b0;
  int unsigned m_clean = 0;
  int unsigned m_abort = 0;
  logic [63:0] fw [0:15];
  int          fn;
  logic [7:0]  fkeep;
  int          fund;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic void push(input logic [7:0] c, input logic [63:0] d, input bit eof);
    col_t e;
    e.eof  = eof;
    e.ctrl = c;
    e.data = d;
    exp_q.push_back(e);
  endfunction

  // Reference: the full column sequence a frame must produce, from start to its last gap idle.
  function automatic void model_frame();
    int          k;
    logic [7:0]  m;
    logic [63:0] col;
    bit          done;
    done = 1'b0;
    push(8'h01, START64, 1'b0);
    for (int i = 0; i < fn && !done; i++) begin
      if (i == fund) begin
        push(8'hFF, ERR64, 1'b0);
        for (int j = 0; j < fn - i; j++) push(8'hFF, IDLE64, 1'b0);
        m_abort++;
        done = 1'b1;
      end else if (i < fn - 1) begin
        if (i >= MAXW) begin
          push(8'hFF, ERR64, 1'b0);
          for (int j = 0; j < fn - 1 - i; j++) push(8'hFF, IDLE64, 1'b0);
          m_abort++;
          done = 1'b1;
        end else begin
          push(8'h00, fw[i], 1'b0);
        end
      end else begin
        k = $countones(fkeep);
        m = 8'((16'd1 << k) - 16'd1);
        if (fkeep == 8'hFF) begin
          push(8'h00, fw[i], 1'b0);
          push(8'hFF, TERM64, 1'b0);
          m_clean++;
        end else if (k > 0 && fkeep == m) begin
          col = fw[i];
          for (int j = 0; j < 8; j++) begin
            if (j == k) col[8*j +: 8] = 8'hFD;
            else if (j > k) col[8*j +: 8] = 8'h07;
          end
          push(~m, col, 1'b0);
          m_clean++;
        end else begin
          push(8'hFF, ERR64, 1'b0);
          m_abort++;
        end
      end
    end
    for (int j = 0; j < IFG_N; j++) push(8'hFF, IDLE64, j == IFG_N - 1);
  endfunction

  task automatic put(input logic [63:0] d, input bit last, input logic [7:0] keep);
    int t;
    t = 0;
    bus.valid = 1'b1;
    bus.data  = d;
    bus.last  = last;
    bus.keep  = keep;
    while (!bus.ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!bus.ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=ready_low required=ready_high");
    end
    @(negedge clk);
  endtask

  task automatic drive_frame();
    for (int i = 0; i < fn; i++) begin
      if (i == fund) begin
        bus.valid = 1'b0;
        @(negedge clk);
      end
      put(fw[i], i == fn - 1, (i == fn - 1) ? fkeep : 8'($urandom));
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    bus.valid = 1'b0;
    while ((exp_q.size() != 0 || in_frame) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0 || in_frame) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic check_counts(input string name);
    logic [15:0] ef, ee;
`ifdef MII_TX_STATS_EN
    ef = 16'(m_clean);
    ee = 16'(m_abort);
`else
    ef = 16'h0000;
    ee = 16'h0000;
`endif
    chk({name, "_frame_cnt"}, {56'd0, frame_cnt}, {56'd0, ef});
    chk({name, "_err_cnt"}, {56'd0, err_cnt}, {56'd0, ee});
  endtask

  function automatic logic [71:0] q_at(input int back);
    col_t e;
    e = exp_q[exp_q.size() - back];
    return {e.ctrl, e.data};
  endfunction

  // Column compare: idles between frames only while no word is offered, else the model's next column
  initial begin
    bit   v;
    col_t e;
    forever begin
      @(posedge clk);
      v = bus.valid;
      #1;
      if (cmp_en) begin
        if (!in_frame && !v) begin
          chk("gap_idle", {tx_ctrl, tx_data}, {8'hFF, IDLE64});
          chk("gap_ready", {71'd0, bus.ready}, 72'd0);
        end else if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL extra_column actual=%h_%h required=none", tx_ctrl, tx_data);
        end else begin
          e = exp_q.pop_front();
          chk("column", {tx_ctrl, tx_data}, {e.ctrl, e.data});
          in_frame = !e.eof;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int sz;
    bus.valid = 1'b0;
    bus.data  = 64'd0;
    bus.last  = 1'b0;
    bus.keep  = 8'd0;
    repeat (3) @(negedge clk);
    chk("reset_column", {tx_ctrl, tx_data}, {8'hFF, IDLE64});
    chk("reset_ready", {71'd0, bus.ready}, 72'd0);
    chk("reset_counters", {40'd0, frame_cnt, err_cnt}, 72'd0);
    rst    = 1'b0;
    cmp_en = 1'b1;
    repeat (4) @(negedge clk);

    // One full word, keep FF
    fn = 1; fw[0] = {8{8'hAA}}; fkeep = 8'hFF; fund = -1;
    model_frame();
    chk("pin_start", q_at(5), {8'h01, 64'hD5555555555555FB});
    chk("pin_data", q_at(4), {8'h00, 64'hAAAAAAAAAAAAAAAA});
    chk("pin_term", q_at(3), {8'hFF, 64'h07070707070707FD});
    drive_frame();

    // Partial last word, three lanes kept
    fn = 1; fw[0] = 64'h332211; fkeep = 8'h07; fund = -1;
    model_frame();
    chk("pin_partial", q_at(3), {8'hF8, 64'h07070707FD332211});
    drive_frame();

    // Underrun after three words, six more words drained
    fn = 9; fund = 3; fkeep = 8'hFF;
    for (int i = 0; i < fn; i++) fw[i] = {$urandom, $urandom};
    sz = exp_q.size();
    model_frame();
    chk("pin_underrun_len", {40'd0, 32'(exp_q.size() - sz)}, {40'd0, 32'd13});
    chk("pin_underrun_err", q_at(9), {8'hFF, 64'hFEFEFEFEFEFEFEFE});
    drive_frame();
    wait_drain();
    check_counts("underrun");

    // Frame longer than MAX_WORDS
    fn = 6; fund = -1; fkeep = 8'hFF;
    for (int i = 0; i < fn; i++) fw[i] = {$urandom, $urandom};
    model_frame();
    chk("pin_overlong_err", q_at(4), {8'hFF, 64'hFEFEFEFEFEFEFEFE});
    drive_frame();

    // Non-contiguous keep
    fn = 2; fund = -1; fkeep = 8'h05;
    for (int i = 0; i < fn; i++) fw[i] = {$urandom, $urandom};
    model_frame();
    drive_frame();

    for (int f = 0; f < 40; f++) begin
      fn = $urandom_range(1, 7);
      for (int i = 0; i < fn; i++) fw[i] = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        1: begin
          k = $urandom_range(1, 7);
          fkeep = 8'((16'd1 << k) - 16'd1);
        end
        2: fkeep = 8'($urandom);
        default: fkeep = 8'hFF;
      endcase
      fund = -1;
      if (fn > 1 && $urandom_range(0, 3) == 0)
        fund = $urandom_range(1, (fn - 1 < MAXW) ? fn - 1 : MAXW);
      model_frame();
      drive_frame();
    end
    wait_drain();
    check_counts("random");

    // Asynchronous reset in the middle of a frame
    cmp_en = 1'b0;
    put(64'h1111, 1'b0, 8'h00);
    put(64'h2222, 1'b0, 8'h00);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_column", {tx_ctrl, tx_data}, {8'hFF, IDLE64});
    chk("midrst_ready", {71'd0, bus.ready}, 72'd0);
    chk("midrst_counters", {40'd0, frame_cnt, err_cnt}, 72'd0);
    @(negedge clk);
    bus.valid = 1'b0;
    rst = 1'b0;
    exp_q.delete();
    in_frame = 1'b0;
    m_clean = 0;
    m_abort = 0;
    cmp_en = 1'b1;
    fn = 2; fund = -1; fkeep = 8'h0F;
    for (int i = 0; i < fn; i++) fw[i] = {$urandom, $urandom};
    model_frame();
    drive_frame();
    wait_drain();
    check_counts("after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
